// File: rtl/decode_stage.sv
// Registered RV64 decode stage: immediate generation, register read capture,
// memory address precompute and load-use interlock via a pending-load scoreboard.
module decode_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] ra1,
    output logic [REG_AW-1:0] ra2,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              flush,
    input  logic              wb_clr_valid,
    input  logic [REG_AW-1:0] wb_clr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_srca,
    output logic [XLEN-1:0]   out_srcb,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_dst,
    output logic [XLEN-1:0]   out_mem_addr,
    output logic              out_is_load,
    output logic              out_is_store
);

    localparam int NREG = 1 << REG_AW;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    logic [6:0]        opcode;
    logic              sign;
    imm_fmt_e          fmt;
    logic              use1;
    logic              use2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] dst;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic [XLEN-1:0]   mem_addr;
    logic              hazard;
    logic              fire;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_live;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;

    assign opcode    = in_instr[6:0];
    assign sign      = in_instr[31];
    assign ra1       = REG_AW'(in_instr[19:15]);
    assign ra2       = REG_AW'(in_instr[24:20]);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign dst       = (is_branch | is_store) ? '0 : REG_AW'(in_instr[11:7]);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        fmt  = IMM_I;
        use1 = 1'b1;
        use2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin fmt = IMM_U; use1 = 1'b0; end
            OP_JAL:           begin fmt = IMM_J; use1 = 1'b0; end
            OP_BRANCH:        begin fmt = IMM_B; use2 = 1'b1; end
            OP_STORE:         begin fmt = IMM_S; use2 = 1'b1; end
            OP_OP, OP_OP32:   use2 = 1'b1;
            default:          ;
        endcase
    end

    always_comb begin
        imm = {{(XLEN-12){sign}}, in_instr[31:20]};
        case (fmt)
            IMM_S: imm = {{(XLEN-12){sign}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: imm = {{(XLEN-12){sign}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-32){sign}}, in_instr[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-20){sign}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default: ;
        endcase
    end

    assign mem_addr = (is_load | is_store) ? rd1 + imm : '0;

    // A write-back clearing a register this cycle already unblocks its reader.
    assign clr_mask  = wb_clr_valid ? (NREG'(1) << wb_clr_addr) : '0;
    assign pend_live = pend & ~clr_mask;

    assign hazard = in_valid &
                    ((use1 & (ra1 != '0) & pend_live[ra1]) |
                     (use2 & (ra2 != '0) & pend_live[ra2]));

    assign in_ready = (~out_valid | out_ready) & ~hazard;
    assign fire     = in_valid & in_ready & ~flush;

    assign set_mask = (fire & is_load & (dst != '0)) ? (NREG'(1) << dst) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            pend <= (pend_live | set_mask) & ~NREG'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Data fields only move on an accepted instruction; otherwise they hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_pc       <= '0;
            out_srca     <= '0;
            out_srcb     <= '0;
            out_imm      <= '0;
            out_dst      <= '0;
            out_mem_addr <= '0;
            out_is_load  <= 1'b0;
            out_is_store <= 1'b0;
        end else if (fire) begin
            out_pc       <= in_pc;
            out_srca     <= rd1;
            out_srcb     <= rd2;
            out_imm      <= imm;
            out_dst      <= dst;
            out_mem_addr <= mem_addr;
            out_is_load  <= is_load;
            out_is_store <= is_store;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_decode_stage;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic              flush;
    logic              wb_clr_valid;
    logic [REG_AW-1:0] wb_clr_addr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_srca;
    logic [XLEN-1:0]   out_srcb;
    logic [XLEN-1:0]   out_imm;
    logic [REG_AW-1:0] out_dst;
    logic [XLEN-1:0]   out_mem_addr;
    logic              out_is_load;
    logic              out_is_store;

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .flush(flush), .wb_clr_valid(wb_clr_valid), .wb_clr_addr(wb_clr_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_srca(out_srca), .out_srcb(out_srcb), .out_imm(out_imm), .out_dst(out_dst),
        .out_mem_addr(out_mem_addr), .out_is_load(out_is_load), .out_is_store(out_is_store)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        longint imm;
        int     dst;
        bit     use1;
        bit     use2;
        bit     ld;
        bit     st;
    } dec_t;

    // Reference model state: what the output register and scoreboard should hold.
    bit              m_valid = 0;
    logic [XLEN-1:0] m_pc = '0, m_srca = '0, m_srcb = '0, m_imm = '0, m_addr = '0;
    int              m_dst = 0;
    bit              m_ld = 0, m_st = 0;
    bit              m_pend[32];
    bit              ready_seen;

    function automatic longint sext(longint u, int w);
        if (u >= (longint'(1) << (w - 1))) return u - (longint'(1) << w);
        return u;
    endfunction

    function automatic dec_t model_decode(logic [31:0] ins);
        dec_t d;
        logic [6:0] op = ins[6:0];
        d.dst  = int'(ins[11:7]);
        d.use1 = 1;
        d.use2 = 0;
        d.ld   = (op == 7'h03);
        d.st   = (op == 7'h23);
        d.imm  = sext(longint'(ins[31:20]), 12);
        case (op)
            7'h37, 7'h17: begin
                d.imm  = sext(longint'(ins[31:12]) * 4096, 32);
                d.use1 = 0;
            end
            7'h6F: begin
                d.imm  = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                              longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
                d.use1 = 0;
            end
            7'h63: begin
                d.imm  = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                              longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
                d.use2 = 1;
                d.dst  = 0;
            end
            7'h23: begin
                d.imm  = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
                d.use2 = 1;
                d.dst  = 0;
            end
            7'h33, 7'h3B: d.use2 = 1;
            default: ;
        endcase
        if (ins[19:15] == 5'd0) d.use1 = 0;
        if (ins[24:20] == 5'd0) d.use2 = 0;
        return d;
    endfunction

    // One clock of DUT and model: in_ready checked before the edge, outputs after.
    task automatic tick();
        dec_t d;
        bit   hz, exp_ready, fire;
        @(negedge clk);
        d  = model_decode(in_instr);
        hz = in_valid && ((d.use1 && m_pend[in_instr[19:15]] &&
                           !(wb_clr_valid && wb_clr_addr == in_instr[19:15])) ||
                          (d.use2 && m_pend[in_instr[24:20]] &&
                           !(wb_clr_valid && wb_clr_addr == in_instr[24:20])));
        exp_ready = (!m_valid || out_ready) && !hz;
        fire      = in_valid && exp_ready && !flush;
        total_cnt++;
        if (in_ready !== exp_ready) $display("FAIL in_ready: got %b want %b t=%0t", in_ready, exp_ready, $time);
        else pass_cnt++;
        total_cnt++;
        if (ra1 !== in_instr[19:15] || ra2 !== in_instr[24:20])
            $display("FAIL ra: got %0d/%0d want %0d/%0d", ra1, ra2, in_instr[19:15], in_instr[24:20]);
        else pass_cnt++;
        ready_seen = in_ready;
        @(posedge clk);
        if (wb_clr_valid) m_pend[wb_clr_addr] = 0;
        if (fire && d.ld && d.dst != 0) m_pend[d.dst] = 1;
        m_pend[0] = 0;
        if (fire) begin
            m_pc   = in_pc;
            m_srca = rd1;
            m_srcb = rd2;
            m_imm  = d.imm;
            m_dst  = d.dst;
            m_ld   = d.ld;
            m_st   = d.st;
            m_addr = (d.ld || d.st) ? rd1 + d.imm : 64'd0;
        end
        if (flush) m_valid = 0;
        else if (fire) m_valid = 1;
        else if (out_ready) m_valid = 0;
        #1;
        total_cnt++;
        if (out_valid !== m_valid) $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_valid, $time);
        else pass_cnt++;
        total_cnt++;
        if (out_pc !== m_pc) $display("FAIL out_pc: got %h want %h", out_pc, m_pc);
        else pass_cnt++;
        total_cnt++;
        if (out_srca !== m_srca || out_srcb !== m_srcb)
            $display("FAIL out_src: got %h/%h want %h/%h", out_srca, out_srcb, m_srca, m_srcb);
        else pass_cnt++;
        total_cnt++;
        if (out_imm !== m_imm) $display("FAIL out_imm: got %h want %h", out_imm, m_imm);
        else pass_cnt++;
        total_cnt++;
        if (out_dst !== REG_AW'(m_dst)) $display("FAIL out_dst: got %0d want %0d", out_dst, m_dst);
        else pass_cnt++;
        total_cnt++;
        if (out_mem_addr !== m_addr) $display("FAIL out_mem_addr: got %h want %h", out_mem_addr, m_addr);
        else pass_cnt++;
        total_cnt++;
        if (out_is_load !== m_ld || out_is_store !== m_st)
            $display("FAIL out_kind: got ld=%b st=%b want ld=%b st=%b", out_is_load, out_is_store, m_ld, m_st);
        else pass_cnt++;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] a, input logic [63:0] b);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        rd1      = a;
        rd2      = b;
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        out_ready    = 1'b1;
        flush        = 1'b0;
        wb_clr_valid = 1'b0;
        wb_clr_addr  = '0;
        drive(0, 32'h0000_0013, 64'd0, 64'd0, 64'd0);
        foreach (m_pend[i]) m_pend[i] = 0;
        #22;
        total_cnt++;
        if (out_valid !== 1'b0 || out_pc !== '0 || out_imm !== '0 || out_dst !== '0 ||
            out_mem_addr !== '0 || out_srca !== '0 || out_is_load !== 1'b0 || out_is_store !== 1'b0)
            $display("FAIL reset_outputs: got valid=%b pc=%h imm=%h want all zero", out_valid, out_pc, out_imm);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        drive(1, 32'hFFD0_8293, 64'h100, 64'd10, 64'd0);
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFD || out_dst !== 5'd5 ||
            out_srca !== 64'd10 || out_mem_addr !== 64'd0)
            $display("FAIL addi: got v=%b imm=%h dst=%0d srca=%0d addr=%h want 1/FFFFFFFFFFFFFFFD/5/10/0",
                     out_valid, out_imm, out_dst, out_srca, out_mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        drive(1, 32'h0081_3303, 64'h104, 64'h1000, 64'd0);
        tick();
        total_cnt++;
        if (out_mem_addr !== 64'h1008 || out_is_load !== 1'b1 || out_dst !== 5'd6)
            $display("FAIL ld_addr: got addr=%h ld=%b dst=%0d want 1008/1/6", out_mem_addr, out_is_load, out_dst);
        else pass_cnt++;
        drive(1, 32'h0013_03B3, 64'h108, 64'h55, 64'h66);
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (ready_seen !== 1'b0) $display("FAIL load_use_stall: got in_ready=%b want 0", ready_seen);
            else pass_cnt++;
        end
        wb_clr_valid = 1'b1;
        wb_clr_addr  = 5'd6;
        tick();
        total_cnt++;
        if (ready_seen !== 1'b1 || out_dst !== 5'd7 || out_pc !== 64'h108)
            $display("FAIL load_use_release: got ready=%b dst=%0d pc=%h want 1/7/108", ready_seen, out_dst, out_pc);
        else pass_cnt++;
        wb_clr_valid = 1'b0;
        in_valid     = 1'b0;
        tick();
    endtask

    task automatic test_store_lui_beq();
        drive(1, 32'hFE32_3C23, 64'h200, 64'h2000, 64'h33);
        tick();
        total_cnt++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8 || out_mem_addr !== 64'h1FF8 || out_dst !== 5'd0 ||
            out_is_store !== 1'b1)
            $display("FAIL sd: got imm=%h addr=%h dst=%0d st=%b want -8/1FF8/0/1",
                     out_imm, out_mem_addr, out_dst, out_is_store);
        else pass_cnt++;
        drive(1, 32'h8000_00B7, 64'h204, 64'd0, 64'd0);
        tick();
        total_cnt++;
        if (out_imm !== 64'hFFFF_FFFF_8000_0000 || out_dst !== 5'd1)
            $display("FAIL lui: got imm=%h dst=%0d want FFFFFFFF80000000/1", out_imm, out_dst);
        else pass_cnt++;
        drive(1, 32'hFE20_8EE3, 64'h208, 64'd1, 64'd2);
        tick();
        total_cnt++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || out_dst !== 5'd0)
            $display("FAIL beq: got imm=%h dst=%0d want FFFFFFFFFFFFFFFC/0", out_imm, out_dst);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        drive(1, 32'hFFD0_8293, 64'h300, 64'd7, 64'd0);
        tick();
        out_ready = 1'b0;
        drive(1, 32'h8000_00B7, 64'h304, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (ready_seen !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h300 ||
                out_imm !== 64'hFFFF_FFFF_FFFF_FFFD)
                $display("FAIL backpressure_hold: got ready=%b v=%b pc=%h imm=%h want 0/1/300/-3",
                         ready_seen, out_valid, out_pc, out_imm);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if (ready_seen !== 1'b1 || out_pc !== 64'h304)
            $display("FAIL backpressure_release: got ready=%b pc=%h want 1/304", ready_seen, out_pc);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        drive(1, 32'h0001_3483, 64'h400, 64'h10, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid);
        else pass_cnt++;
        drive(1, 32'h0094_80B3, 64'h404, 64'd3, 64'd4);
        tick();
        total_cnt++;
        if (ready_seen !== 1'b1 || out_valid !== 1'b1 || out_dst !== 5'd1)
            $display("FAIL flush_no_stall: got ready=%b v=%b dst=%0d want 1/1/1", ready_seen, out_valid, out_dst);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1, {12'(i * 3), 5'd2, 3'b000, 5'd3, 7'h13}, 64'h500 + 64'(i * 4), 64'(i), 64'd0);
            tick();
            total_cnt++;
            if (ready_seen !== 1'b1 || out_pc !== 64'h500 + 64'(i * 4) || out_imm !== 64'(i * 3))
                $display("FAIL back_to_back[%0d]: got ready=%b pc=%h imm=%h want 1/%h/%h",
                         i, ready_seen, out_pc, out_imm, 64'h500 + 64'(i * 4), 64'(i * 3));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h3B, 7'h67};
        logic [31:0] ins;
        for (int n = 0; n < 600; n++) begin
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, ins, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom});
            out_ready    = $urandom_range(0, 3) != 0;
            flush        = $urandom_range(0, 9) == 0;
            wb_clr_valid = $urandom_range(0, 2) == 0;
            wb_clr_addr  = 5'($urandom_range(0, 7));
            tick();
        end
        in_valid     = 1'b0;
        flush        = 1'b0;
        wb_clr_valid = 1'b0;
        out_ready    = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_store_lui_beq();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
